// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared seven-segment patterns and scan phase type
// Patterns are active-high, bit 0 = segment a through bit 6 = segment g.
package display_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h7C;
   localparam logic [6:0] SEG_C     = 7'h39;
   localparam logic [6:0] SEG_D     = 7'h5E;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } phase_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - nibble to seven-segment pattern, hex or decimal
// Codes 10-15 render as A-F only when i_hex_mode is set, otherwise blank.
module seg7_decode
   import display_pkg::*;
(
   input  logic [3:0] i_nibble,
   input  logic       i_hex_mode,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_nibble)
         4'h0: o_seg = SEG_0;
         4'h1: o_seg = SEG_1;
         4'h2: o_seg = SEG_2;
         4'h3: o_seg = SEG_3;
         4'h4: o_seg = SEG_4;
         4'h5: o_seg = SEG_5;
         4'h6: o_seg = SEG_6;
         4'h7: o_seg = SEG_7;
         4'h8: o_seg = SEG_8;
         4'h9: o_seg = SEG_9;
         4'hA: o_seg = i_hex_mode ? SEG_A : SEG_BLANK;
         4'hB: o_seg = i_hex_mode ? SEG_B : SEG_BLANK;
         4'hC: o_seg = i_hex_mode ? SEG_C : SEG_BLANK;
         4'hD: o_seg = i_hex_mode ? SEG_D : SEG_BLANK;
         4'hE: o_seg = i_hex_mode ? SEG_E : SEG_BLANK;
         4'hF: o_seg = i_hex_mode ? SEG_F : SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/multi_digit_scan_driver.sv
// rtl/multi_digit_scan_driver.sv - N-digit multiplexed seven-segment scanner
// Each slot opens with an all-off interval to stop ghosting between digits.
module multi_digit_scan_driver
   import display_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 1_000_000,
   parameter int BLANK_CYCLES   = 1000,
   parameter int BLINK_FRAMES   = 64,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit SEL_ACTIVE_LOW = 1'b0
)
(
   input  logic                      display_clk,
   input  logic                      i_rst,
   input  logic                      i_en,
   input  logic [4*NUM_DIGITS-1:0]   digits,
   input  logic [NUM_DIGITS-1:0]     dp,
   input  logic [NUM_DIGITS-1:0]     blink_mask,
   input  logic                      hex_mode,
   input  logic                      lz_suppress,
   output logic [7:0]                seg,
   output logic [NUM_DIGITS-1:0]     dig_sel
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CNT_W-1:0]      SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [FRM_W-1:0]      FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
   localparam logic [7:0]            SEG_OFF    = {8{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] SEL_OFF    = {NUM_DIGITS{SEL_ACTIVE_LOW}};

   phase_t                  r_state;
   phase_t                  w_next_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [IDX_W-1:0]        r_idx;
   logic [FRM_W-1:0]        r_frm;
   logic                    r_blink_phase;

   logic [3:0]              r_nib;
   logic                    r_dp;
   logic                    r_blink;
   logic                    r_sup;

   logic                    w_slot_wrap;
   logic                    w_frame_wrap;
   logic                    w_capture;
   logic [3:0]              w_nib_sel;
   logic                    w_dp_sel;
   logic                    w_blink_sel;
   logic                    w_sup_sel;
   logic [NUM_DIGITS-1:0]   w_sel_onehot;
   logic [NUM_DIGITS-1:0]   w_upper_zero;
   logic [6:0]              w_seg7;
   logic                    w_blinked_off;
   logic [7:0]              w_seg_show;
   logic [NUM_DIGITS-1:0]   w_sel_show;

   assign w_slot_wrap  = (r_cnt == SLOT_LAST);
   assign w_frame_wrap = w_slot_wrap && (r_idx == IDX_LAST);
   assign w_capture    = (r_state == BLANK) && (r_cnt == BLANK_LAST);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         BLANK: if (r_cnt == BLANK_LAST) w_next_state = SHOW;
         SHOW:  if (w_slot_wrap)         w_next_state = BLANK;
      endcase
   end

   // w_upper_zero[k] is set when nibbles k..NUM_DIGITS-1 are all zero.
   always_comb begin
      logic acc;
      acc          = 1'b1;
      w_upper_zero = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         acc             = acc && (digits[4*k +: 4] == 4'h0);
         w_upper_zero[k] = acc;
      end
   end

   always_comb begin
      w_nib_sel    = '0;
      w_dp_sel     = 1'b0;
      w_blink_sel  = 1'b0;
      w_sup_sel    = 1'b0;
      w_sel_onehot = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_nib_sel       = digits[4*k +: 4];
            w_dp_sel        = dp[k];
            w_blink_sel     = blink_mask[k];
            w_sup_sel       = lz_suppress && (k != 0) && w_upper_zero[k];
            w_sel_onehot[k] = 1'b1;
         end
      end
   end

   seg7_decode u_decode (
      .i_nibble   (r_nib),
      .i_hex_mode (hex_mode),
      .o_seg      (w_seg7)
   );

   // Blink kills the dp too, but the digit stays selected.
   assign w_blinked_off = r_blink && !r_blink_phase;
   assign w_seg_show    = ((r_state == SHOW) && !w_blinked_off)
                        ? {r_dp, (r_sup ? SEG_BLANK : w_seg7)} : 8'h00;
   assign w_sel_show    = (r_state == SHOW) ? w_sel_onehot : '0;

   always_ff @(posedge display_clk) begin
      if (i_rst) begin
         r_state       <= BLANK;
         r_cnt         <= '0;
         r_idx         <= '0;
         r_frm         <= '0;
         r_blink_phase <= 1'b1;
      end else if (!i_en) begin
         r_state <= BLANK;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_frm   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_slot_wrap ? '0 : r_cnt + CNT_W'(1);
         if (w_slot_wrap)
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
         if (w_frame_wrap) begin
            if (r_frm == FRM_LAST) begin
               r_frm         <= '0;
               r_blink_phase <= ~r_blink_phase;
            end else begin
               r_frm <= r_frm + FRM_W'(1);
            end
         end
      end
   end

   always_ff @(posedge display_clk) begin
      if (i_rst) begin
         r_nib   <= '0;
         r_dp    <= 1'b0;
         r_blink <= 1'b0;
         r_sup   <= 1'b0;
      end else if (i_en && w_capture) begin
         r_nib   <= w_nib_sel;
         r_dp    <= w_dp_sel;
         r_blink <= w_blink_sel;
         r_sup   <= w_sup_sel;
      end
   end

   always_ff @(posedge display_clk) begin
      if (i_rst || !i_en) begin
         seg     <= SEG_OFF;
         dig_sel <= SEL_OFF;
      end else begin
         seg     <= w_seg_show ^ SEG_OFF;
         dig_sel <= w_sel_show ^ SEL_OFF;
      end
   end

endmodule

// File: tb/tb_multi_digit_scan_driver.sv
// tb/tb_multi_digit_scan_driver.sv - directed checks of the N-digit scanner
module tb_multi_digit_scan_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] digits;
   logic [3:0]  dp;
   logic [3:0]  blink_mask;
   logic        hex_mode;
   logic        lz;
   logic [7:0]  seg;
   logic [3:0]  dig_sel;

   logic        p_rst;
   logic [7:0]  p_seg;
   logic [3:0]  p_sel;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [31:0] SEGS_4321 = 32'h664F5B06;

   always #5 clk = ~clk;

   multi_digit_scan_driver #(
      .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .BLINK_FRAMES(2),
      .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)
   ) u_dut (
      .display_clk (clk),
      .i_rst       (rst),
      .i_en        (en),
      .digits      (digits),
      .dp          (dp),
      .blink_mask  (blink_mask),
      .hex_mode    (hex_mode),
      .lz_suppress (lz),
      .seg         (seg),
      .dig_sel     (dig_sel)
   );

   multi_digit_scan_driver #(
      .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .BLINK_FRAMES(2),
      .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
   ) u_dut_inv (
      .display_clk (clk),
      .i_rst       (p_rst),
      .i_en        (1'b1),
      .digits      (16'h0001),
      .dp          (4'b0000),
      .blink_mask  (4'b0000),
      .hex_mode    (1'b1),
      .lz_suppress (1'b0),
      .seg         (p_seg),
      .dig_sel     (p_sel)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // t counts edges since the frame start: digit j shows after edges 8j+3..8j+8.
   task automatic run_span(input int t0, input int t1, input logic [31:0] segs, input string tag);
      int         j;
      int         c;
      logic [7:0] es;
      logic [3:0] ed;
      for (int t = t0; t <= t1; t++) begin
         tick();
         j = (t - 1) / 8;
         c = (t - 1) % 8;
         if (c >= 2) begin
            es = segs[8*j +: 8];
            ed = 4'b0001 << j;
         end else begin
            es = 8'h00;
            ed = 4'b0000;
         end
         check($sformatf("%s t%0d seg", tag, t), 32'(seg), 32'(es));
         check($sformatf("%s t%0d sel", tag, t), 32'(dig_sel), 32'(ed));
      end
   endtask

   initial begin
      rst        = 1'b1;
      p_rst      = 1'b1;
      en         = 1'b1;
      digits     = 16'h4321;
      dp         = 4'b0000;
      blink_mask = 4'b0000;
      hex_mode   = 1'b1;
      lz         = 1'b0;
      tick();
      tick();
      check("reset seg", 32'(seg), 32'h00);
      check("reset sel", 32'(dig_sel), 32'h0);
      check("inv reset seg", 32'(p_seg), 32'hFF);
      check("inv reset sel", 32'(p_sel), 32'hF);
      rst   = 1'b0;
      p_rst = 1'b0;
      tick();
      check("inv e1 seg", 32'(p_seg), 32'hFF);
      tick();
      check("inv e2 sel", 32'(p_sel), 32'hF);
      tick();
      check("inv e3 seg", 32'(p_seg), 32'hF9);
      check("inv e3 sel", 32'(p_sel), 32'hE);

      do_reset();
      run_span(1, 32, SEGS_4321, "basic_f0");
      run_span(1, 32, SEGS_4321, "basic_f1");

      digits = 16'hFA0B;
      run_span(1, 32, 32'h71773F7C, "hex_on");
      hex_mode = 1'b0;
      run_span(1, 32, 32'h00003F00, "hex_off");

      hex_mode = 1'b1;
      lz       = 1'b1;
      digits   = 16'h0005;
      dp       = 4'b0100;
      run_span(1, 32, 32'h0080006D, "lz_0005");
      digits = 16'h0000;
      dp     = 4'b0000;
      run_span(1, 32, 32'h0000003F, "lz_0000");

      lz         = 1'b0;
      digits     = 16'h8888;
      blink_mask = 4'b0010;
      do_reset();
      run_span(1, 32, 32'h7F7F7F7F, "blink_f0");
      run_span(1, 32, 32'h7F7F7F7F, "blink_f1");
      run_span(1, 32, 32'h7F7F007F, "blink_f2");
      run_span(1, 32, 32'h7F7F007F, "blink_f3");
      run_span(1, 32, 32'h7F7F7F7F, "blink_f4");

      blink_mask = 4'b0000;
      digits     = 16'h4321;
      do_reset();
      run_span(1, 4, SEGS_4321, "midchg_a");
      digits = 16'h9999;
      run_span(5, 32, 32'h6F6F6F06, "midchg_b");

      digits = 16'h4321;
      do_reset();
      run_span(1, 5, SEGS_4321, "en_pre");
      en = 1'b0;
      tick();
      check("en_off seg", 32'(seg), 32'h00);
      check("en_off sel", 32'(dig_sel), 32'h0);
      tick();
      check("en_off2 sel", 32'(dig_sel), 32'h0);
      en = 1'b1;
      run_span(1, 32, SEGS_4321, "en_resume");

      do_reset();
      run_span(1, 12, SEGS_4321, "rst_pre");
      rst = 1'b1;
      tick();
      check("rst_mid seg", 32'(seg), 32'h00);
      check("rst_mid sel", 32'(dig_sel), 32'h0);
      rst = 1'b0;
      run_span(1, 32, SEGS_4321, "rst_resume");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/multi_digit_scan_driver.md
# multi_digit_scan_driver

Time-multiplexed seven-segment display driver for N digits: the next generation of the four-digit scanner. It adds a parameterised digit count, an anti-ghosting blank interval between digits, hex/decimal decode, per-digit decimal points, per-digit blink, leading-zero suppression and selectable output polarity. It runs directly on display_clk with an internal enable-based prescaler, so no derived clock is needed, and drives the board's shared segment bus and digit-select lines.

## Interface
- NUM_DIGITS, 4: number of digits scanned, 2..8.
- REFRESH_DIV, 1_000_000: display_clk cycles per digit slot, ≥ 4.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all outputs off; 1 ≤ BLANK_CYCLES < REFRESH_DIV.
- BLINK_FRAMES, 64: full scan frames per blink half-period, ≥ 1.
- SEG_ACTIVE_LOW, 0: 1 inverts seg.
- SEL_ACTIVE_LOW, 0: 1 inverts dig_sel.
- display_clk  in  1  block clock.
- i_rst  in  1  reset: synchronous, active-high, on display_clk.
- i_en  in  1  scan enable; low blanks the display.
- digits  in  4*NUM_DIGITS  nibble k = digits[4k+3:4k]; k=0 is least significant.
- dp  in  NUM_DIGITS  decimal point per digit.
- blink_mask  in  NUM_DIGITS  1 = digit blinks.
- hex_mode  in  1  1 = codes 10–15 show A–F; 0 = codes 10–15 blank.
- lz_suppress  in  1  1 = blank leading zeros.
- seg  out  8  bits 0–6 = segments a–g, bit 7 = dp; registered.
- dig_sel  out  NUM_DIGITS  one-hot digit enable; registered.

## Operation
- Slot counter cnt runs 0..REFRESH_DIV-1. Digit index idx runs 0..NUM_DIGITS-1 and advances when cnt wraps; it wraps from NUM_DIGITS-1 to 0. One frame is one pass over all indices.
- Phase FSM has two states per slot:
  - BLANK while cnt < BLANK_CYCLES.
  - SHOW while cnt ≥ BLANK_CYCLES.
- BLANK → SHOW when cnt = BLANK_CYCLES-1.
- SHOW → BLANK at the slot wrap.
- Capture: digit nibble, dp bit, blink bit and suppression flag for idx are captured on the cycle cnt = BLANK_CYCLES-1. They are held for the whole SHOW phase, so input changes mid-slot have no visible effect.
- Leading-zero suppression: digit k is blanked when lz_suppress=1, k ≠ 0, and nibbles k..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed. A suppressed digit still shows its dp.
- Decode, active-high:
  - 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - A–F: 77 7C 39 5E 79 71.
  - Blank: 00.
  - seg[7] = captured dp.
- Blink: a frame counter toggles blink_phase every BLINK_FRAMES frames. While blink_phase=0 and the captured blink bit=1, seg = all off (dp included). dig_sel is still asserted.
- BLANK phase: seg and dig_sel all off.
- i_en=0: synchronously forces idx=0, cnt=0, state BLANK and the frame counter to 0. blink_phase is held. Outputs are off on the next cycle. Scanning resumes from digit 0 when i_en returns to 1.
- Polarity: "off" means all-zero before inversion. With SEG_ACTIVE_LOW=1 off is seg=8'hFF; with SEL_ACTIVE_LOW=1 off is all-ones on dig_sel.
- Reset values:
  - cnt=0, idx=0, state BLANK.
  - frame counter 0, blink_phase=1 (visible).
  - seg and dig_sel off, per polarity.

## Timing
- Outputs are registered from the FSM state, so they lag the state by one cycle.
- With i_rst released before edge 1 and i_en=1:
  - dig_sel[0] asserts after edge BLANK_CYCLES+1.
  - It stays asserted for REFRESH_DIV-BLANK_CYCLES cycles.
  - Outputs are then off for BLANK_CYCLES cycles before dig_sel[1].
- Consecutive slots never overlap; at most one dig_sel bit is active on any cycle.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles.
- Blink period = 2*BLINK_FRAMES frames.
- blink_phase toggles on the cycle the last slot of the BLINK_FRAMES-th frame wraps.
- i_rst asserted mid-SHOW: outputs are off on the next cycle; all state returns to reset values. i_rst has priority over i_en.

## Structure
- Package display_pkg:
  - SEG_* constants for 0–F and SEG_BLANK.
  - Phase enum {BLANK, SHOW}.
- Sub-module seg7_decode: combinational nibble + hex_mode → 7-bit pattern. It is reused by other display blocks.
- The top level holds the prescaler/slot counter, idx, phase FSM, capture registers, leading-zero logic, blink frame counter and output registers.

## Test plan
All cases use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2, active-high, unless stated.
- Basic scan: digits=16'h4321, dp=0 → per 32-cycle frame, dig_sel=0001,0010,0100,1000 each active 6 cycles with 2 off-cycles between. seg=06,5B,4F,66. At most one dig_sel bit is ever high.
- Hex vs decimal: digits=16'hFA0B with hex_mode=1 → seg 7C,3F,77,71. With hex_mode=0 → 00,3F,00,00.
- Leading zeros: digits=16'h0005, lz_suppress=1, dp=4'b0100 → digits 3 and 1 show 00, digit 2 shows 80, digit 0 shows 6D. digits=16'h0000 → only digit 0 shows 3F.
- Blink: blink_mask=4'b0010, digits=16'h8888 → digit 1 shows 7F for 2 frames then 00 for 2 frames, repeating. The other digits always show 7F.
- Mid-slot change, enable and reset:
  - digits changed during a SHOW phase → no change until the next capture.
  - i_en=0 mid-slot → outputs off next cycle; on re-enable, dig_sel=0001 after 3 edges.
  - i_rst mid-slot → same off/restart behaviour.
- Polarity: SEG_ACTIVE_LOW=1 and SEL_ACTIVE_LOW=1 → reset values seg=FF and dig_sel=1111. Digit 0 of 16'h0001 shows seg=F9 with dig_sel=1110.
